// File: rtl/add_pkg.sv
// Shared types and constants for the word-serial multiword adder.
package add_pkg;
  localparam int unsigned ADDER_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/word_adder32.sv
// Single 32-bit combinational ripple stage shared by every word of the operation.
module word_adder32
  import add_pkg::*;
(
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               cin,
  output logic [ADDER_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = (ADDER_W+1)'(a) + (ADDER_W+1)'(b) + (ADDER_W+1)'(cin);

endmodule

// File: rtl/multiword_add_seq.sv
// Multiword add/subtract processed one 32-bit word per cycle, LSW first,
// with valid/ready handshakes on both operand and result sides.
module multiword_add_seq
  import add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDER_W*WORDS-1:0]   a,
  input  logic [ADDER_W*WORDS-1:0]   b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDER_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  state_t                            state;
  state_t                            state_nxt;
  logic [WORDS-1:0][ADDER_W-1:0]     a_r;
  logic [WORDS-1:0][ADDER_W-1:0]     b_r;
  logic [WORDS-1:0][ADDER_W-1:0]     sum_w;
  logic                              carry;
  logic [IDX_W-1:0]                  idx;
  logic [ADDER_W-1:0]                ws;
  logic                              wc;
  logic                              accept;
  logic                              last;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IDX_W'(WORDS - 1));
  assign sum       = sum_w;

  word_adder32 u_adder (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .sum  (ws),
    .cout (wc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded into the capture as A + ~B + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum_w <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_w[idx] <= ws;
          carry      <= wc;
          idx        <= idx + IDX_W'(1);
          if (last) begin
            cout <= wc;
            ovf  <= (a_r[WORDS-1][ADDER_W-1] == b_r[WORDS-1][ADDER_W-1]) &&
                    (ws[ADDER_W-1] != a_r[WORDS-1][ADDER_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and streaming checks of multiword_add_seq against a full-width reference model.
module tb_multiword_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    logic [W-1:0] be;
    logic [W:0]   full;
    res_t         r;
    be     = s ? ~y : y;
    full   = (W+1)'(x) + (W+1)'(be) + (W+1)'(s ? 1'b1 : ci);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == be[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(WORDS); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_sum"},  (W+1)'(sum),  (W+1)'(e.sum));
    chk({tag, "_cout"}, (W+1)'(cout), (W+1)'(e.cout));
    chk({tag, "_ovf"},  (W+1)'(ovf),  (W+1)'(e.ovf));
  endtask

  // One full transaction: accept, measure latency, compare, hand off.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input string tag);
    int   lat;
    res_t e;
    chk({tag, "_in_ready"}, (W+1)'(in_ready), (W+1)'(1'b1));
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(x, y, ci, s));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, (W+1)'(lat), (W+1)'(WORDS));
    e = exp_q.pop_front();
    if (out_valid) begin
      chk_res(tag, e);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_out_valid_after"}, (W+1)'(out_valid), (W+1)'(1'b0));
      chk({tag, "_in_ready_after"},  (W+1)'(in_ready),  (W+1)'(1'b1));
    end
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] xs;
    logic [W-1:0] ys;
    logic         cs;
    logic         ss;
    res_t         e;
    int           lat;
    int           last_acc;
    int           n_acc;
    logic         acc;
    logic         hs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b0));
    chk("rst_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
    chk("rst_sum",       (W+1)'(sum),       (W+1)'(0));
    chk("rst_cout",      (W+1)'(cout),      (W+1)'(1'b0));
    chk("rst_ovf",       (W+1)'(ovf),       (W+1)'(1'b0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", (W+1)'(in_ready), (W+1)'(1'b1));

    // Spec vectors, then the held result checked against literal values.
    run_op({W{1'b1}}, W'(1), 1'b0, 1'b0, "ones_plus1");
    chk("ones_plus1_hold_sum",  (W+1)'(sum),  (W+1)'(0));
    chk("ones_plus1_hold_cout", (W+1)'(cout), (W+1)'(1'b1));
    chk("ones_plus1_hold_ovf",  (W+1)'(ovf),  (W+1)'(1'b0));

    run_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, "maxpos_plus1");
    chk("maxpos_hold_sum",  (W+1)'(sum),  (W+1)'({1'b1, {(W-1){1'b0}}}));
    chk("maxpos_hold_cout", (W+1)'(cout), (W+1)'(1'b0));
    chk("maxpos_hold_ovf",  (W+1)'(ovf),  (W+1)'(1'b1));

    run_op(W'(5), W'(7), 1'b0, 1'b1, "five_minus_seven");
    chk("fmn_hold_sum",  (W+1)'(sum),  (W+1)'({{(W-1){1'b1}}, 1'b0}));
    chk("fmn_hold_cout", (W+1)'(cout), (W+1)'(1'b0));
    chk("fmn_hold_ovf",  (W+1)'(ovf),  (W+1)'(1'b0));

    run_op({32'h0, {(W-32){1'b1}}}, W'(0), 1'b1, 1'b0, "cin_ripple");
    run_op({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1, 1'b1, "minneg_sub_cin_ignored");
    for (int i = 0; i < 6; i++) begin
      run_op(rnd(), rnd(), 1'($urandom()), 1'($urandom()), "random");
    end

    // Stall in DONE with an in_valid pulse that must not be captured.
    x = rnd(); y = rnd();
    a = x; b = y; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(x, y, 1'b0, 1'b0));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("stall_latency", (W+1)'(lat), (W+1)'(WORDS));
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", (W+1)'(out_valid), (W+1)'(1'b1));
      chk("stall_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b0));
      chk("stall_sum",       (W+1)'(sum),       (W+1)'(e.sum));
      if (i == 3) begin
        a = rnd(); b = rnd(); sub = 1'b1; in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      tick();
    end
    chk_res("stall_result", e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stall_no_capture", (W+1)'(out_valid), (W+1)'(1'b0));
      tick();
    end

    // Reset during the second RUN cycle abandons the operation.
    a = rnd(); b = rnd(); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", (W+1)'(out_valid), (W+1)'(1'b0));
    chk("midrst_sum",       (W+1)'(sum),       (W+1)'(0));
    chk("midrst_in_ready",  (W+1)'(in_ready),  (W+1)'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", (W+1)'(in_ready), (W+1)'(1'b1));
    for (int i = 0; i < int'(WORDS) + 2; i++) begin
      tick();
      chk("midrst_no_result", (W+1)'(out_valid), (W+1)'(1'b0));
    end

    // Back-to-back streaming with both handshakes held high.
    xs = rnd(); ys = rnd(); cs = 1'($urandom()); ss = 1'($urandom());
    a = xs; b = ys; cin = cs; sub = ss;
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        chk("stream_pending", (W+1)'(exp_q.size() > 0), (W+1)'(1'b1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_res("stream", e);
        end
      end
      if (acc) begin
        exp_q.push_back(model(xs, ys, cs, ss));
        if (last_acc >= 0) chk("stream_interval", (W+1)'(cyc - last_acc), (W+1)'(WORDS + 2));
        last_acc = cyc;
        n_acc++;
      end
      tick();
      if (acc) begin
        xs = rnd(); ys = rnd(); cs = 1'($urandom()); ss = 1'($urandom());
        a = xs; b = ys; cin = cs; sub = ss;
      end
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk_res("drain", e);
      end
      tick();
    end
    chk("stream_queue_empty", (W+1)'(exp_q.size()), (W+1)'(0));
    chk("stream_accept_count", (W+1)'(n_acc), (W+1)'(7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
